// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction boot loader.
//   state_t        : loader framing states
//   BYTE_W/WORD_W  : stream byte and instruction word widths
//   LEN_W          : width of the frame length header (word count)
package instr_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  // States in which the loader takes bytes from the host link.
  function automatic logic accepts_bytes(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/instr_loader_byte_word_asm.sv
// Little-endian byte-to-word assembler.
//   clk, reset    : clock, synchronous active-low reset
//   clear         : synchronous clear (loader re-arm)
//   byte_en       : a stream byte is accepted this cycle
//   byte_in       : the accepted byte
//   last_byte_c   : next accepted byte completes a word (combinational)
//   word_valid    : one-cycle pulse, word_data holds a completed word
//   word_data     : assembled word, byte0 in bits [7:0]
module byte_word_asm
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              last_byte_c,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [1:0]         idx_q;
  logic [SHIFT_W-1:0] shift_q;

  assign last_byte_c = (idx_q == 2'd3);

  // Bytes shift in from the top so the first byte ends up lowest.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx_q      <= 2'd0;
      shift_q    <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        idx_q <= idx_q + 2'd1;
        if (last_byte_c) begin
          word_data  <= {byte_in, shift_q};
          word_valid <= 1'b1;
        end else begin
          shift_q <= {byte_in, shift_q[SHIFT_W-1:BYTE_W]};
        end
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream boot loader: parses a length-framed, XOR-checksummed byte
// stream, writes little-endian 32-bit words to sequential imem addresses
// and holds the core in reset until a good frame has been loaded.
//   clk, reset   : clock, synchronous active-low reset
//   in_valid/in_data/in_ready : host byte stream handshake
//   start        : re-arm pulse, honoured only in DONE or ERR
//   imem_we/imem_addr/imem_wdata : imem write port (one pulse per word)
//   cpu_reset    : core reset, released only after a good load
//   done, error  : load outcome levels
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]     imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  // Capacity in words, wide enough to compare against any 16-bit header.
  localparam logic [32:0] DEPTH_L = 33'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [BYTE_W-1:0]     len_lo_q, len_lo_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      word_cnt_q, word_cnt_d;
  logic [BYTE_W-1:0]     chk_q, chk_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  cpu_reset_d, done_d, error_d;

  logic                  accept_c;
  logic                  byte_en_c;
  logic                  clear_c;
  logic                  last_byte_c;
  logic [LEN_W-1:0]      len_rx_c;

  // Ready is withheld while reset is asserted so no byte is lost to it.
  assign in_ready = reset && accepts_bytes(state_q);
  assign accept_c = in_valid && in_ready;
  assign len_rx_c = {in_data, len_lo_q};

  byte_word_asm u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_c),
    .byte_en     (byte_en_c),
    .byte_in     (in_data),
    .last_byte_c (last_byte_c),
    .word_valid  (imem_we),
    .word_data   (imem_wdata)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    chk_d       = chk_q;
    addr_d      = imem_addr;
    cpu_reset_d = cpu_reset;
    done_d      = done;
    error_d     = error;
    byte_en_c   = 1'b0;
    clear_c     = 1'b0;

    unique case (state_q)
      LEN_LO: begin
        if (accept_c) begin
          len_lo_d = in_data;
          chk_d    = chk_q ^ in_data;
          state_d  = LEN_HI;
        end
      end

      LEN_HI: begin
        if (accept_c) begin
          len_d = len_rx_c;
          chk_d = chk_q ^ in_data;
          if (33'(len_rx_c) > DEPTH_L) begin
            state_d = ERR;
            error_d = 1'b1;
          end else if (len_rx_c == '0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept_c) begin
          chk_d     = chk_q ^ in_data;
          byte_en_c = 1'b1;
          // Address is latched alongside the assembled word so both
          // appear together on the write pulse.
          if (last_byte_c) begin
            addr_d     = ADDR_WIDTH'(word_cnt_q);
            word_cnt_d = word_cnt_q + LEN_W'(1);
            if ((word_cnt_q + LEN_W'(1)) == len_q) begin
              state_d = CHK;
            end
          end
        end
      end

      CHK: begin
        if (accept_c) begin
          if (in_data == chk_q) begin
            state_d     = DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end

      DONE, ERR: begin
        if (start) begin
          state_d     = LEN_LO;
          clear_c     = 1'b1;
          len_lo_d    = '0;
          len_d       = '0;
          word_cnt_d  = '0;
          chk_d       = '0;
          addr_d      = '0;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end
      end

      default: begin
        state_d = LEN_LO;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= LEN_LO;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      chk_q      <= '0;
      imem_addr  <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      chk_q      <= chk_d;
      imem_addr  <= addr_d;
      cpu_reset  <= cpu_reset_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

endmodule
